// File: rtl/fir_soc_pkg.sv
// Shared definitions for the FIR job sequencer slice: data widths, default
// run timeout, the sequencer state encoding and a small RF address helper.
package fir_soc_pkg;

    localparam int RF_ADDR_W              = 5;
    localparam int DATA_W                 = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        KICK,
        RUN,
        DONE,
        TOUT
    } seqState_e;

    // Register x0 is hardwired to zero in the core, so writes to it are dropped.
    function automatic logic isWritableReg(input logic [RF_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/fir_job_sequencer_if.sv
// Bundle of the host-side preload/control signals and the core-side RF/run
// pins handled by the FIR job sequencer. The slave modport is the sequencer's
// view; the master modport is the host/core environment's view.
interface fir_job_sequencer_if;
    import fir_soc_pkg::*;

    logic                 job_start;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [RF_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 fir_rf_we;
    logic [RF_ADDR_W-1:0] fir_rf_waddr;
    logic [DATA_W-1:0]    fir_rf_wdata;
    logic                 core_hold;
    logic                 fir_start;
    logic                 fir_done;
    logic                 busy;
    logic                 job_done;
    logic                 job_timeout;
    logic [DATA_W-1:0]    run_cycles;

    modport slave (
        input  job_start, wr_valid, wr_addr, wr_data, fir_done,
        output wr_ready, fir_rf_we, fir_rf_waddr, fir_rf_wdata, core_hold,
               fir_start, busy, job_done, job_timeout, run_cycles
    );

    modport master (
        output job_start, wr_valid, wr_addr, wr_data, fir_done,
        input  wr_ready, fir_rf_we, fir_rf_waddr, fir_rf_wdata, core_hold,
               fir_start, busy, job_done, job_timeout, run_cycles
    );

endinterface

// File: rtl/fir_run_timer.sv
// Saturating run-length counter with a timeout compare. 'expired' is high in
// the cycle whose increment brings the count up to 'limit', so the owner can
// leave its run state on that same edge.
module fir_run_timer
    import fir_soc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] limit,
    output logic [DATA_W-1:0] count,
    output logic              expired
);

    localparam logic [DATA_W-1:0] COUNT_MAX = '1;

    // Count enabled cycles, restart on clear, stick at the all-ones value.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != COUNT_MAX)) begin
            count <= count + DATA_W'(1);
        end
    end

    assign expired = (count >= (limit - DATA_W'(1)));

endmodule

// File: rtl/fir_job_sequencer.sv
// Runs one FIR job on the core: streams RF preload words into the core's
// side-port while it is held in reset, keeps it held a few cycles, releases
// it with a start pulse, then waits for done or a timeout and reports the
// outcome and run length to the host.
module fir_job_sequencer
    import fir_soc_pkg::*;
#(
    parameter int NUM_WRITES     = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int HOLD_CYCLES    = 2
) (
    input logic                clock,
    input logic                reset,
    fir_job_sequencer_if.slave bus
);

    localparam int WORD_CNT_W = 5;
    localparam int HOLD_CNT_W = 16;

    seqState_e             state;
    seqState_e             nextState;
    logic [WORD_CNT_W-1:0] wordCount;
    logic [HOLD_CNT_W-1:0] holdCount;
    logic                  accept;
    logic                  lastWord;
    logic                  holdDone;
    logic                  firstRunCycle;

    logic                  wrReady;
    logic                  coreHold;
    logic                  firStart;
    logic                  busy;
    logic                  jobDone;
    logic                  jobTimeout;
    logic                  timerClear;
    logic                  timerEnable;
    logic                  timerExpired;
    logic [DATA_W-1:0]     runCount;

    logic                  rfWe;
    logic [RF_ADDR_W-1:0]  rfWaddr;
    logic [DATA_W-1:0]     rfWdata;

    // Accept is derived from state directly so it does not loop through wrReady.
    assign accept        = bus.wr_valid && (state == LOAD);
    assign lastWord      = (wordCount == WORD_CNT_W'(NUM_WRITES - 1));
    assign holdDone      = (holdCount == HOLD_CNT_W'(HOLD_CYCLES - 1));
    // The timer is cleared in KICK, so a zero count inside RUN marks the first
    // run cycle, when the core PC is still leaving reset and done is unreliable.
    assign firstRunCycle = (runCount == '0);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and Moore outputs of the job sequence.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        nextState   = state;
        wrReady     = 1'b0;
        coreHold    = 1'b1;
        firStart    = 1'b0;
        busy        = 1'b1;
        jobDone     = 1'b0;
        jobTimeout  = 1'b0;
        timerClear  = 1'b0;
        timerEnable = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.job_start) nextState = LOAD;
            end
            LOAD: begin
                wrReady = 1'b1;
                if (accept && lastWord) nextState = HOLD;
            end
            HOLD: begin
                if (holdDone) nextState = KICK;
            end
            KICK: begin
                coreHold   = 1'b0;
                firStart   = 1'b1;
                timerClear = 1'b1;
                nextState  = RUN;
            end
            RUN: begin
                coreHold    = 1'b0;
                timerEnable = 1'b1;
                // Done takes priority over a timeout landing on the same cycle.
                if (bus.fir_done && !firstRunCycle) begin
                    nextState = DONE;
                end else if (timerExpired) begin
                    nextState = TOUT;
                end
            end
            DONE: begin
                jobDone   = 1'b1;
                nextState = IDLE;
            end
            TOUT: begin
                jobTimeout = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Preload word counter; restarts whenever the sequencer is idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wordCount <= '0;
        end else if (state == IDLE) begin
            wordCount <= '0;
        end else if (accept) begin
            wordCount <= wordCount + WORD_CNT_W'(1);
        end
    end

    // Hold-phase counter; runs only while in HOLD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            holdCount <= '0;
        end else if (state == HOLD) begin
            holdCount <= holdCount + HOLD_CNT_W'(1);
        end else begin
            holdCount <= '0;
        end
    end

    // Registered RF write port: one strobe per accepted word, x0 suppressed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rfWe    <= 1'b0;
            rfWaddr <= '0;
            rfWdata <= '0;
        end else begin
            rfWe <= accept && isWritableReg(bus.wr_addr);
            if (accept) begin
                rfWaddr <= bus.wr_addr;
                rfWdata <= bus.wr_data;
            end
        end
    end

    fir_run_timer runTimer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timerClear),
        .enable  (timerEnable),
        .limit   (DATA_W'(TIMEOUT_CYCLES)),
        .count   (runCount),
        .expired (timerExpired)
    );

    assign bus.wr_ready     = wrReady;
    assign bus.core_hold    = coreHold;
    assign bus.fir_start    = firStart;
    assign bus.busy         = busy;
    assign bus.job_done     = jobDone;
    assign bus.job_timeout  = jobTimeout;
    assign bus.run_cycles   = runCount;
    assign bus.fir_rf_we    = rfWe;
    assign bus.fir_rf_waddr = rfWaddr;
    assign bus.fir_rf_wdata = rfWdata;

endmodule

// File: tb/tb_fir_job_sequencer.sv
// Directed-plus-random bench for fir_job_sequencer. A queue model records the
// RF writes the core should see; run outcome and latency come from a simple
// rule: the run ends at the first fir_done seen after the first run cycle,
// or after TIMEOUT_CYCLES run cycles, whichever is earlier.
module tb_fir_job_sequencer;
    import fir_soc_pkg::*;

    localparam int NUM_WRITES     = 16;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int HOLD_CYCLES    = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fir_job_sequencer_if bus ();

    fir_job_sequencer #(
        .NUM_WRITES     (NUM_WRITES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cycleCnt    = 0;
    int errors      = 0;
    int checks      = 0;
    int startPulses = 0;
    int donePulses  = 0;
    int toutPulses  = 0;
    int lastAcceptCycle = 0;

    // Entries are {cycle the write is visible, rf index, rf data}.
    logic [63:0] expWrites[$];
    logic [63:0] obsWrites[$];

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Observe the core-side pins once per cycle, away from the clock edge.
    always @(negedge clock) begin
        if (bus.fir_rf_we) obsWrites.push_back({27'(cycleCnt), bus.fir_rf_waddr, bus.fir_rf_wdata});
        if (bus.fir_start) startPulses++;
        if (bus.job_done) donePulses++;
        if (bus.job_timeout) toutPulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit runEndsByDone(input int doneDelay);
        return (doneDelay >= 2) && (doneDelay <= TIMEOUT_CYCLES);
    endfunction

    task automatic checkIdleOutputs(input string tag);
        check({tag, ":wr_ready"},    bus.wr_ready,    0);
        check({tag, ":core_hold"},   bus.core_hold,   1);
        check({tag, ":busy"},        bus.busy,        0);
        check({tag, ":fir_start"},   bus.fir_start,   0);
        check({tag, ":job_done"},    bus.job_done,    0);
        check({tag, ":job_timeout"}, bus.job_timeout, 0);
        check({tag, ":fir_rf_we"},   bus.fir_rf_we,   0);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first LOAD cycle.
    task automatic startJob(input string name);
        bus.job_start = 1'b1;
        @(posedge clock); #1;
        bus.job_start = 1'b0;
        check({name, ":wr_ready_after_start"}, bus.wr_ready, 1);
        check({name, ":busy_after_start"}, bus.busy, 1);
    endtask

    task automatic loadWords(input int n, input bit gaps, input bit randData, input int zeroIdx,
                             input bit pokeStart);
        int idx    = 0;
        int budget = 0;
        logic [4:0]  a;
        logic [31:0] d;
        while (idx < n && budget < 400) begin
            a = (idx == zeroIdx) ? 5'd0 : 5'(idx + 1);
            d = randData ? $urandom : (32'h100 + 32'(idx));
            bus.wr_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wr_addr   = a;
            bus.wr_data   = d;
            bus.job_start = pokeStart && (idx == 3);
            @(negedge clock);
            if (bus.wr_valid && bus.wr_ready) begin
                if (a != 5'd0) expWrites.push_back({27'(cycleCnt + 1), a, d});
                lastAcceptCycle = cycleCnt;
                idx++;
            end
            budget++;
            @(posedge clock); #1;
        end
        bus.job_start = 1'b0;
        check("load:accepts", idx, n);
        if (n == NUM_WRITES) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 5'd31;
            bus.wr_data  = 32'hBAD0_0000;
            @(negedge clock);
            check("load:extra_word_refused", bus.wr_ready, 0);
            @(posedge clock); #1;
        end
        bus.wr_valid = 1'b0;
    endtask

    // Plays the core: optional done in the first run cycle, then done from doneDelay on (0 = never).
    task automatic runCore(input string name, input bit earlyPulse, input int doneDelay);
        bit          seen       = 0;
        int          startCycle = 0;
        int          j          = 0;
        bit          ended      = 0;
        logic        gotDone    = 1'b0;
        logic        gotTout    = 1'b0;
        logic [31:0] gotCycles  = '0;
        bit          expDone;
        int          endAt;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.fir_start) begin
                seen = 1;
                startCycle = cycleCnt;
                check({name, ":core_released_at_start"}, bus.core_hold, 0);
            end
        end
        check({name, ":fir_start_seen"}, seen, 1);
        check({name, ":accept_to_start"}, startCycle - lastAcceptCycle, HOLD_CYCLES + 1);
        expDone = runEndsByDone(doneDelay);
        endAt   = expDone ? doneDelay : TIMEOUT_CYCLES;
        while (!ended && j < TIMEOUT_CYCLES + 20) begin
            @(posedge clock); #1;
            j++;
            bus.fir_done = (earlyPulse && j == 1) || (doneDelay > 0 && j >= doneDelay);
            @(negedge clock);
            if (bus.job_done || bus.job_timeout) begin
                ended     = 1;
                gotDone   = bus.job_done;
                gotTout   = bus.job_timeout;
                gotCycles = bus.run_cycles;
                check({name, ":core_hold_at_end"}, bus.core_hold, 1);
            end
        end
        check({name, ":run_ended"}, ended, 1);
        check({name, ":end_cycle"}, j, endAt + 1);
        check({name, ":job_done"}, gotDone, expDone);
        check({name, ":job_timeout"}, gotTout, !expDone);
        check({name, ":run_cycles"}, gotCycles, endAt);
    endtask

    // Full job from an IDLE cycle back to the first IDLE cycle after it.
    task automatic doJob(input string name, input bit gaps, input bit randData, input int zeroIdx,
                         input bit earlyPulse, input int doneDelay, input bit pokeStart);
        int s0;
        int d0;
        int t0;
        bit expDone;
        expWrites.delete();
        obsWrites.delete();
        s0 = startPulses;
        d0 = donePulses;
        t0 = toutPulses;
        expDone = runEndsByDone(doneDelay);
        startJob(name);
        loadWords(NUM_WRITES, gaps, randData, zeroIdx, pokeStart);
        runCore(name, earlyPulse, doneDelay);
        @(posedge clock); #1;
        bus.fir_done = 1'b0;
        check({name, ":busy_after_end"}, bus.busy, 0);
        check({name, ":core_hold_after_end"}, bus.core_hold, 1);
        check({name, ":rf_write_count"}, obsWrites.size(), expWrites.size());
        for (int i = 0; i < expWrites.size() && i < obsWrites.size(); i++) begin
            check({name, ":rf_write"}, obsWrites[i], expWrites[i]);
        end
        check({name, ":start_pulses"}, startPulses - s0, 1);
        check({name, ":done_pulses"}, donePulses - d0, expDone ? 1 : 0);
        check({name, ":timeout_pulses"}, toutPulses - t0, expDone ? 0 : 1);
    endtask

    initial begin
        int d0;
        int t0;
        bus.job_start = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.fir_done  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        checkIdleOutputs("reset");
        check("reset:run_cycles", bus.run_cycles, 0);
        check("reset:fir_rf_waddr", bus.fir_rf_waddr, 0);
        check("reset:fir_rf_wdata", bus.fir_rf_wdata, 0);
        reset = 1'b1;

        // Preload words offered while idle are never acknowledged.
        @(posedge clock); #1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd9;
        bus.wr_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clock);
            check("idle:wr_ready", bus.wr_ready, 0);
        end
        @(posedge clock); #1;
        bus.wr_valid = 1'b0;
        @(negedge clock);
        check("idle:no_rf_write", obsWrites.size(), 0);
        @(posedge clock); #1;

        // Jobs run back to back: each next job_start lands in the first IDLE cycle.
        doJob("nominal", 0, 0, -1, 0, 40, 0);
        doJob("gaps", 1, 1, -1, 0, int'($urandom_range(2, 300)), 1);
        doJob("x0_filter", 1, 1, 5, 0, 100, 0);
        doJob("timeout", 0, 1, -1, 0, 0, 0);
        doJob("tie_early", 0, 1, -1, 1, TIMEOUT_CYCLES, 0);

        // Asynchronous reset in the middle of a load.
        expWrites.delete();
        obsWrites.delete();
        startJob("mid_reset");
        loadWords(7, 0, 1, -1, 0);
        d0 = donePulses;
        t0 = toutPulses;
        reset = 1'b0;
        #1;
        checkIdleOutputs("mid_reset");
        check("mid_reset:run_cycles", bus.run_cycles, 0);
        check("mid_reset:fir_rf_waddr", bus.fir_rf_waddr, 0);
        check("mid_reset:fir_rf_wdata", bus.fir_rf_wdata, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_reset:busy_after_release", bus.busy, 0);
        check("mid_reset:no_done_pulse", donePulses - d0, 0);
        check("mid_reset:no_timeout_pulse", toutPulses - t0, 0);

        doJob("after_reset", 1, 1, -1, 0, 50, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_job_sequencer.md
Name: fir_job_sequencer

Overview:
- Sequences one FIR job on the processor core: streams register-file preload words (coefficients, samples, pointers) into the core's RF side-port, holds the core in reset while loading, releases it, pulses fir_start and waits for fir_done.
- Supervises each run with a timeout and reports completion, timeout and run latency to the SoC host/scheduler.
- Sits between the host-side control logic and the processor core's fir_rf_*/fir_start/fir_done/reset pins.

Parameters:
- NUM_WRITES, 16, RF words accepted per job (1..31).
- TIMEOUT_CYCLES, 1024, max RUN cycles before a timeout is declared (>=2).
- HOLD_CYCLES, 2, cycles core_hold stays asserted after the last preload write (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_start  in  1  request a job; sampled only in IDLE.
- wr_valid  in  1  preload word valid.
- wr_ready  out  1  preload word accepted when wr_valid&&wr_ready.
- wr_addr  in  5  target RF index.
- wr_data  in  32  RF data.
- fir_rf_we  out  1  RF write strobe to core.
- fir_rf_waddr  out  5  RF write index to core.
- fir_rf_wdata  out  32  RF write data to core.
- core_hold  out  1  1 = core held in reset; the integration maps this to the core reset pin polarity.
- fir_start  out  1  one-cycle start pulse to core.
- fir_done  in  1  core completion level (PC reached end address).
- busy  out  1  high in every state except IDLE.
- job_done  out  1  one-cycle pulse on normal completion.
- job_timeout  out  1  one-cycle pulse on timeout.
- run_cycles  out  32  cycles from fir_start to fir_done (or to timeout) of the last job; held until the next fir_start.

Behaviour:
- Reset values:
  - State IDLE.
  - core_hold=1; all other outputs 0; run_cycles=0.
- States:
  - IDLE:
    - wr_ready=0, core_hold=1.
    - job_start -> LOAD; word counter cleared.
  - LOAD:
    - wr_ready=1.
    - Each handshake drives fir_rf_we/waddr/wdata registered, one cycle after acceptance, with one write per accepted word and no backpressure stalls internally.
    - wr_addr==0 is accepted and counted, but fir_rf_we stays 0 (x0 is not writable).
    - When the NUM_WRITES-th word is accepted: wr_ready drops the next cycle, hold counter cleared -> HOLD.
  - HOLD:
    - core_hold=1 for HOLD_CYCLES cycles; the first of these covers the final registered RF write.
    - Then -> KICK.
  - KICK:
    - core_hold=0, fir_start=1 for exactly this cycle.
    - run_cycles cleared to 0 -> RUN.
  - RUN:
    - run_cycles increments every cycle, saturating at 2^32-1.
    - Ends at fir_done==1 or at the timeout, whichever comes first.
    - fir_done is ignored in the first RUN cycle, because the core PC is only just leaving reset.
    - fir_done==1 -> DONE.
    - Otherwise, when run_cycles reaches TIMEOUT_CYCLES -> TOUT.
    - If both occur in the same cycle, fir_done wins.
  - DONE:
    - job_done=1 for one cycle, core_hold=1 -> IDLE.
  - TOUT:
    - job_timeout=1 for one cycle, core_hold=1 -> IDLE.
- Latency:
  - job_start -> first wr_ready = 1 cycle.
  - Last accept -> fir_start = HOLD_CYCLES+1 cycles.
  - fir_done -> job_done = 1 cycle.
- Simultaneous events and boundaries:
  - job_start outside IDLE is ignored (no queuing).
  - wr_valid outside LOAD is ignored and never acknowledged.
  - Words beyond NUM_WRITES are not accepted.
  - busy falls in the same cycle IDLE is entered, so it is low in the cycle after the job_done/job_timeout pulse.
  - A new job_start in that first IDLE cycle is accepted.
- Asynchronous reset mid-job:
  - Immediately returns to IDLE with core_hold=1.
  - No done/timeout pulse is produced.
  - A partially loaded RF is not cleaned; the next job reloads it.

Decomposition:
- Shared package fir_soc_pkg holds:
  - the state enum (IDLE, LOAD, HOLD, KICK, RUN, DONE, TOUT);
  - RF_ADDR_W=5 and DATA_W=32;
  - the default TIMEOUT_CYCLES.
- One natural sub-module: fir_run_timer. It is the saturating 32-bit run counter plus timeout compare, with inputs clear, enable and limit, and outputs count and expired.

Test Plan:
- Nominal:
  - Stimulus: job_start, then 16 words with addr=i+1, data=0x100+i, wr_valid held high; fir_done asserted 40 cycles after fir_start.
  - Required: 16 fir_rf_we pulses with matching addr/data; fir_start 3 cycles after the last accept; job_done once; run_cycles=40; busy low afterwards.
- Backpressure/gaps:
  - Stimulus: wr_valid toggled randomly.
  - Required: exactly 16 writes, in order, no duplicates.
- x0 filter:
  - Stimulus: word 5 uses addr=0.
  - Required: only 15 fir_rf_we pulses, job still proceeds after 16 accepts.
- Timeout:
  - Stimulus: fir_done never asserted.
  - Required: job_timeout pulse exactly when run_cycles=1024; core_hold=1 afterwards; no job_done.
- Tie and early done:
  - Stimulus: fir_done asserted in the first RUN cycle, then deasserted.
  - Required: that first-cycle assertion is ignored.
  - Stimulus: fir_done asserted at cycle 1024.
  - Required: job_done, not job_timeout.
- Reset mid-LOAD:
  - Stimulus: reset pulled low after 7 accepts.
  - Required: outputs return to their reset values at once; the next job_start accepts a full 16 words.
